path_traceback: RTL
===================

Name: path_traceback

Overview:
- Reads the direction memory P produced by the shortest-path solver and walks from the bottom-right cell (ROWS-1, COLS-1) back to the Start cell (0,0).
- Writes each visited cell's direction code, in visit order, into a result memory R.
- Reports the path length, a one-cycle Done pulse and an error flag.
- Sits after the solver on the P memory port; it is the consumer of the P memory the solver writes.

Parameters:
ROWS, 4, grid rows (I index)
COLS, 4, grid columns (J index)
D_WIDTH, 8, data width of P and R memories
A_WIDTH, 13, address width of P and R memories
P_BASE, 0, base address of P matrix
R_BASE, 0, base address of R output buffer

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  synchronous active-high reset
Go  input  1  start request, sampled in IDLE only
P_In  input  D_WIDTH  P memory read data
P_Addr  output  A_WIDTH  P memory address
P_En  output  1  P memory enable
P_Rw  output  1  P read/write, always 0 (read only)
R_Out  output  D_WIDTH  R memory write data
R_Addr  output  A_WIDTH  R memory address
R_En  output  1  R memory enable
R_Rw  output  1  R read/write, 1 = write
Len  output  D_WIDTH  number of entries written to R; held until next Go
Err  output  1  malformed path detected; held until next Go
Done  output  1  one-cycle completion pulse (success or error)

Behaviour:
- Reset: one clock with Rst=1 forces the following, regardless of state (including mid-walk):
  - all outputs 0; I=ROWS-1, J=COLS-1, k=0; state IDLE.
  - An aborted walk leaves R partially written and does not pulse Done.
- Direction codes: Start=8'h08, Right=8'h09, Down=8'h0A.
- Memory timing: address and enable are presented in cycle t; P_In is valid in cycle t+1. Memory outputs are Moore-decoded from the state and are 0 in every state that does not drive them.
- States:
  - IDLE: Go=1 loads I=ROWS-1, J=COLS-1, k=0, clears Len and Err, then goes to RD. Otherwise stays in IDLE.
  - RD: P_En=1, P_Rw=0, P_Addr=P_BASE+I*COLS+J (truncated to A_WIDTH). Next state CAP.
  - CAP: latch C=P_In. Next state CHK.
  - CHK: validate C at (I,J).
    - Start legal only when I==0 and J==0.
    - Right legal only when J>0.
    - Down legal only when I>0.
    - Any other code is illegal.
    - Illegal code: Err<=1, no write, go to DONE.
    - Legal code: R_En=1, R_Rw=1, R_Addr=R_BASE+k, R_Out=C, k<=k+1, Len<=k+1.
      - Right: J<=J-1, go to RD.
      - Down: I<=I-1, go to RD.
      - Start: go to DONE.
  - DONE: Done=1 for exactly one cycle, then IDLE.
- Step cost: 3 cycles per entry (RD, CAP, CHK). A successful walk writes ROWS+COLS-1 entries.
- Go while not in IDLE is ignored. Go held high in DONE is seen only after returning to IDLE.
- Termination: every legal non-Start step decrements I or J, so a walk always ends within ROWS+COLS-1 entries.
- Rst and Go asserted together: Rst wins.
- Len and Err reflect the last run, remain stable in IDLE, and are cleared on the next accepted Go.

Test Plan:
- 4x4, row 0 = {08,09,09,09}, column 3 rows 1-3 = 0A, Go pulse in cycle 0 -> R[0..6] = 0A,0A,0A,09,09,09,08; Len=7; Err=0; Done high in cycle 22 only; P_Rw never 1.
- 4x4 staircase P[3][3]=09, P[3][2]=0A, P[2][2]=09, P[2][1]=0A, P[1][1]=09, P[1][0]=0A, P[0][0]=08 -> R[0..6] = 09,0A,09,0A,09,0A,08; P_Addr sequence 15,14,10,9,5,4,0.
- Right at J==0: P[3][3]=09, P[3][2]=09, P[3][1]=09, P[3][0]=09 -> 3 entries written, Err=1, Len=3, Done pulses, no R write for the fourth read.
- Illegal code 8'h00 at (3,3) -> Err=1, Len=0, no R_En assertion; Start at (2,3) also -> Err=1.
- Rst asserted during the second CHK of the first scenario -> next cycle all outputs 0, state IDLE, no Done. A fresh Go then reproduces the full first-scenario result.
- Go toggled every cycle during a walk -> result identical to the first scenario; Done pulses exactly once.

Source files
------------

// File: rtl/path_traceback.sv
// Walks the solver's direction matrix from (ROWS-1, COLS-1) back to (0,0),
// copying each visited direction code into the result buffer in visit order.
module path_traceback #(
   parameter int unsigned ROWS    = 4,
   parameter int unsigned COLS    = 4,
   parameter int unsigned D_WIDTH = 8,
   parameter int unsigned A_WIDTH = 13,
   parameter int unsigned P_BASE  = 0,
   parameter int unsigned R_BASE  = 0
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Go,
   input  logic [D_WIDTH-1:0] P_In,
   output logic [A_WIDTH-1:0] P_Addr,
   output logic               P_En,
   output logic               P_Rw,
   output logic [D_WIDTH-1:0] R_Out,
   output logic [A_WIDTH-1:0] R_Addr,
   output logic               R_En,
   output logic               R_Rw,
   output logic [D_WIDTH-1:0] Len,
   output logic               Err,
   output logic               Done
);

   localparam int unsigned IW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned JW = (COLS > 1) ? $clog2(COLS) : 1;

   localparam logic [D_WIDTH-1:0] CODE_START = D_WIDTH'(8'h08);
   localparam logic [D_WIDTH-1:0] CODE_RIGHT = D_WIDTH'(8'h09);
   localparam logic [D_WIDTH-1:0] CODE_DOWN  = D_WIDTH'(8'h0A);

   localparam logic [IW-1:0] I_LAST = IW'(ROWS - 1);
   localparam logic [JW-1:0] J_LAST = JW'(COLS - 1);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_CHK, S_DONE} state_t;

   state_t             state;
   logic [IW-1:0]      i;
   logic [JW-1:0]      j;
   logic [D_WIDTH-1:0] k;
   logic [D_WIDTH-1:0] c;
   logic               legal;

   function automatic logic [A_WIDTH-1:0] p_addr_of(input logic [IW-1:0] ii,
                                                    input logic [JW-1:0] jj);
      return A_WIDTH'(P_BASE + 32'(ii) * COLS + 32'(jj));
   endfunction

   function automatic logic is_legal(input logic [D_WIDTH-1:0] code,
                                     input logic [IW-1:0]      ii,
                                     input logic [JW-1:0]      jj);
      logic ok;
      ok = 1'b0;
      if (code == CODE_START)      ok = (ii == '0) && (jj == '0);
      else if (code == CODE_RIGHT) ok = (jj != '0);
      else if (code == CODE_DOWN)  ok = (ii != '0);
      return ok;
   endfunction

   // The P port is read-only from this block.
   assign P_Rw = 1'b0;

   // Outputs are registered on the transition into the state that owns them,
   // so each is high exactly for the cycles spent in that state.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= S_IDLE;
         i      <= I_LAST;
         j      <= J_LAST;
         k      <= '0;
         c      <= '0;
         legal  <= 1'b0;
         P_Addr <= '0;
         P_En   <= 1'b0;
         R_Out  <= '0;
         R_Addr <= '0;
         R_En   <= 1'b0;
         R_Rw   <= 1'b0;
         Len    <= '0;
         Err    <= 1'b0;
         Done   <= 1'b0;
      end else begin
         P_Addr <= '0;
         P_En   <= 1'b0;
         R_Out  <= '0;
         R_Addr <= '0;
         R_En   <= 1'b0;
         R_Rw   <= 1'b0;
         Done   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (Go) begin
                  i      <= I_LAST;
                  j      <= J_LAST;
                  k      <= '0;
                  Len    <= '0;
                  Err    <= 1'b0;
                  P_En   <= 1'b1;
                  P_Addr <= p_addr_of(I_LAST, J_LAST);
                  state  <= S_RD;
               end
            end
            S_RD: state <= S_CAP;
            S_CAP: begin
               // Validate here so the R write strobe is registered for CHK.
               c     <= P_In;
               legal <= is_legal(P_In, i, j);
               if (is_legal(P_In, i, j)) begin
                  R_En   <= 1'b1;
                  R_Rw   <= 1'b1;
                  R_Addr <= A_WIDTH'(R_BASE + 32'(k));
                  R_Out  <= P_In;
               end
               state <= S_CHK;
            end
            S_CHK: begin
               if (!legal) begin
                  Err   <= 1'b1;
                  Done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  k   <= k + D_WIDTH'(1);
                  Len <= k + D_WIDTH'(1);
                  if (c == CODE_RIGHT) begin
                     j      <= j - JW'(1);
                     P_En   <= 1'b1;
                     P_Addr <= p_addr_of(i, j - JW'(1));
                     state  <= S_RD;
                  end else if (c == CODE_DOWN) begin
                     i      <= i - IW'(1);
                     P_En   <= 1'b1;
                     P_Addr <= p_addr_of(i - IW'(1), j);
                     state  <= S_RD;
                  end else begin
                     Done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
